en_pulse_gen: RTL and testbench
===============================

EN_PULSE_GEN -- requirements
Module: en_pulse_gen

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the period counter and of period_val.
REQ-002 SHALL have parameter BURST_W, default 8: width of burst_len and of the burst counter.
REQ-003 SHALL have port clk, input, 1: clock; all state changes on the rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port period_val, input, CNT_W: enable period P in cycles; 0 is treated as 1.
REQ-006 SHALL have port burst_len, input, BURST_W: pulse count per run; 0 means unlimited.
REQ-007 SHALL have port mode, input, 1: 0 is periodic, 1 is one-shot; latched with the configuration.
REQ-008 SHALL have port cfg_valid, input, 1: configuration offer.
REQ-009 SHALL have port cfg_ready, output, 1: configuration accepted when high.
REQ-010 SHALL have port start, input, 1: begin a run.
REQ-011 SHALL have port stop, input, 1: abort a run.
REQ-012 SHALL have port en_out, output, 1: single-cycle enable strobe to downstream enabled flops.
REQ-013 SHALL have port busy, output, 1: high while a run is active.
REQ-014 SHALL have port done, output, 1: single-cycle completion pulse.

Function
REQ-015 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-016 SHALL drive cfg_ready=1 only in IDLE; a handshake (cfg_valid & cfg_ready) at an edge SHALL latch period_val, mode and burst_len into internal registers.
REQ-017 SHALL, in IDLE with start=1 and stop=0, move to RUN and load the counter with Peff-1, where Peff = max(P,1).
REQ-018 SHALL, in RUN, drive en_out = (counter==0) combinationally from registered state; en_out SHALL be 0 in IDLE and DONE.
REQ-019 SHALL assert the first en_out in cycle Peff, where cycle 0 is the cycle in which start is sampled; subsequent strobes SHALL follow every Peff cycles.
REQ-020 SHALL, in RUN at counter==0, reload Peff-1; in one-shot mode it SHALL instead go to DONE.
REQ-021 SHALL decrement the counter by 1 in every other RUN cycle, with no wrap below 0.
REQ-022 SHALL hold done=1 for exactly the one DONE cycle, then return to IDLE; busy SHALL equal (state != IDLE).
REQ-023 SHALL, when stop is sampled in RUN, go to IDLE with no done; a strobe due in that same cycle SHALL still appear.
REQ-024 SHALL ignore start in RUN and DONE; start and stop together in IDLE SHALL leave the FSM in IDLE.
REQ-025 SHALL treat a configuration handshake and start in the same IDLE cycle so that the run uses the newly latched values.

Reset
REQ-026 SHALL, on rst=1 at an edge, enter IDLE with counter=0, stored period=1, mode=0 and burst=0; en_out, busy and done SHALL be 0 and cfg_ready SHALL be 1 from the next cycle.
REQ-027 SHALL give rst priority over every other input, including mid-run and during DONE, with no done pulse.

Configuration
REQ-028 SHALL, with macro EN_PULSE_GEN_BURST_EN defined, count strobes in periodic mode; after burst_len strobes (burst_len != 0) it SHALL go to DONE.
REQ-029 SHALL, without EN_PULSE_GEN_BURST_EN, keep the burst_len port, ignore it and build no burst counter; periodic runs SHALL end only by stop or rst.

Verification
REQ-030 SHALL check: rst asserted in cycle 6 of a P=4 periodic run -> en_out, busy and done are 0 from cycle 7, and cfg_ready is 1.
REQ-031 SHALL check: cfg P=4, mode=0, start in cycle 0 -> en_out only in cycles 4, 8, 12, and busy stays 1.
REQ-032 SHALL check: cfg P=3, mode=1, start in cycle 0 -> en_out in cycle 3, done in cycle 4, busy=0 and cfg_ready=1 in cycle 5.
REQ-033 SHALL check: P=4 periodic, stop in cycle 6 -> en_out in cycle 4 only, busy=0 from cycle 7, and no done.
REQ-034 SHALL check: P=0 periodic, start in cycle 0 -> en_out=1 in every cycle from 1 until stop.
REQ-035 SHALL check: burst_len=3, P=2, mode=0 -> with the macro defined, en_out in cycles 2, 4, 6 and done in cycle 7; without it, en_out continues in cycles 8, 10, and so on.

Source files
------------

// File: rtl/en_pulse_gen.sv
// Periodic / one-shot enable strobe generator with a configuration handshake.
// Define EN_PULSE_GEN_BURST_EN to end periodic runs after burst_len strobes.
module en_pulse_gen #(
  parameter int CNT_W   = 16,
  parameter int BURST_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [CNT_W-1:0]   period_val,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               mode,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic               start,
  input  logic               stop,
  output logic               en_out,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   period_q;
  logic               mode_q;
  logic [BURST_W-1:0] burst_q;
  logic               cfg_hs;
  logic [CNT_W-1:0]   start_period;

  // A zero period behaves as a period of one, so the reload value saturates at 0.
  function automatic logic [CNT_W-1:0] reload_val(input logic [CNT_W-1:0] p);
    if (p == '0) reload_val = '0;
    else         reload_val = p - CNT_W'(1);
  endfunction

  assign cfg_ready    = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign cfg_hs       = cfg_valid & cfg_ready;
  // A configuration accepted in the same cycle as start takes effect for that run.
  assign start_period = cfg_hs ? period_val : period_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      period_q <= CNT_W'(1);
      mode_q   <= 1'b0;
      burst_q  <= '0;
    end else if (cfg_hs) begin
      period_q <= period_val;
      mode_q   <= mode;
      burst_q  <= burst_len;
    end
  end

`ifdef EN_PULSE_GEN_BURST_EN
  logic [BURST_W-1:0] bcnt_q, bcnt_d;
  logic               burst_last;

  // Strobe about to be issued is the final one of a limited burst.
  assign burst_last = (burst_q != '0) && (bcnt_q == (burst_q - BURST_W'(1)));

  always_ff @(posedge clk) begin
    if (rst) bcnt_q <= '0;
    else     bcnt_q <= bcnt_d;
  end
`else
  logic unused_burst;
  assign unused_burst = ^burst_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    en_out  = 1'b0;
    done    = 1'b0;
`ifdef EN_PULSE_GEN_BURST_EN
    bcnt_d  = bcnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = RUN;
          cnt_d   = reload_val(start_period);
`ifdef EN_PULSE_GEN_BURST_EN
          bcnt_d  = '0;
`endif
        end
      end
      RUN: begin
        en_out = (cnt_q == '0);
        if (stop) begin
          state_d = IDLE;
        end else if (en_out) begin
          if (mode_q) begin
            state_d = DONE;
          end else begin
            cnt_d = reload_val(period_q);
`ifdef EN_PULSE_GEN_BURST_EN
            if (burst_last) state_d = DONE;
            bcnt_d = bcnt_q + BURST_W'(1);
`endif
          end
        end else begin
          // cnt_q is nonzero here, so the decrement never wraps.
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_en_pulse_gen.sv
// Directed bench for en_pulse_gen; cycle 0 is the cycle in which start is driven.
module tb_en_pulse_gen;
  localparam int CNT_W   = 16;
  localparam int BURST_W = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic [CNT_W-1:0]   period_val;
  logic [BURST_W-1:0] burst_len;
  logic               mode;
  logic               cfg_valid;
  logic               cfg_ready;
  logic               start;
  logic               stop;
  logic               en_out;
  logic               busy;
  logic               done;

  int checks = 0;
  int errors = 0;

  en_pulse_gen #(.CNT_W(CNT_W), .BURST_W(BURST_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .period_val(period_val),
    .burst_len (burst_len),
    .mode      (mode),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .start     (start),
    .stop      (stop),
    .en_out    (en_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    cfg_valid = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
  endtask

  task automatic set_cfg(input int p, input logic m, input int b);
    period_val = CNT_W'(p);
    mode       = m;
    burst_len  = BURST_W'(b);
    cfg_valid  = 1'b1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input int c, input logic e_en,
                            input logic e_busy, input logic e_done, input logic e_rdy);
    chk($sformatf("%s.c%0d.en_out", tag, c), en_out, e_en);
    chk($sformatf("%s.c%0d.busy", tag, c), busy, e_busy);
    chk($sformatf("%s.c%0d.done", tag, c), done, e_done);
    chk($sformatf("%s.c%0d.cfg_ready", tag, c), cfg_ready, e_rdy);
  endtask

  initial begin
    rst = 1'b1;
    period_val = '0;
    burst_len = '0;
    mode = 1'b0;
    clear_inputs();
    step();
    step();
    expect_out("reset", 0, 1'b0, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    step();

    // Periodic P=4, configuration handshake in the start cycle.
    set_cfg(4, 1'b0, 0);
    start = 1'b1;
    expect_out("per4", 0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    clear_inputs();
    for (int c = 1; c <= 13; c++) begin
      expect_out("per4", c, (c % 4 == 0), 1'b1, 1'b0, 1'b0);
      if (c == 13) stop = 1'b1;
      step();
      clear_inputs();
    end
    expect_out("per4", 14, 1'b0, 1'b0, 1'b0, 1'b1);

    // One-shot P=3, configured ahead of start.
    set_cfg(3, 1'b1, 0);
    step();
    clear_inputs();
    start = 1'b1;
    step();
    clear_inputs();
    for (int c = 1; c <= 5; c++) begin
      expect_out("oneshot3", c, (c == 3), (c <= 4), (c == 4), (c == 5));
      step();
    end

    // Stop in cycle 6 of a P=4 periodic run.
    set_cfg(4, 1'b0, 0);
    start = 1'b1;
    step();
    clear_inputs();
    for (int c = 1; c <= 9; c++) begin
      if (c <= 6) expect_out("stop6", c, (c == 4), 1'b1, 1'b0, 1'b0);
      else        expect_out("stop6", c, 1'b0, 1'b0, 1'b0, 1'b1);
      if (c == 6) stop = 1'b1;
      step();
      clear_inputs();
    end

    // Stop on a strobe cycle: the strobe still appears.
    start = 1'b1;
    step();
    clear_inputs();
    for (int c = 1; c <= 5; c++) begin
      if (c <= 4) expect_out("stopstrobe", c, (c == 4), 1'b1, 1'b0, 1'b0);
      else        expect_out("stopstrobe", c, 1'b0, 1'b0, 1'b0, 1'b1);
      if (c == 4) stop = 1'b1;
      step();
      clear_inputs();
    end

    // Reset in cycle 6 of a P=4 periodic run.
    start = 1'b1;
    step();
    clear_inputs();
    for (int c = 1; c <= 6; c++) begin
      expect_out("rst6", c, (c == 4), 1'b1, 1'b0, 1'b0);
      if (c == 6) rst = 1'b1;
      step();
    end
    expect_out("rst6", 7, 1'b0, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;

    // After reset the stored period is 1 and mode is periodic.
    start = 1'b1;
    step();
    clear_inputs();
    expect_out("postrst", 1, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    expect_out("postrst", 2, 1'b1, 1'b1, 1'b0, 1'b0);
    stop = 1'b1;
    step();
    clear_inputs();
    expect_out("postrst", 3, 1'b0, 1'b0, 1'b0, 1'b1);

    // P=0 behaves as P=1: strobe every cycle.
    set_cfg(0, 1'b0, 0);
    start = 1'b1;
    step();
    clear_inputs();
    for (int c = 1; c <= 7; c++) begin
      if (c <= 6) expect_out("p0", c, 1'b1, 1'b1, 1'b0, 1'b0);
      else        expect_out("p0", c, 1'b0, 1'b0, 1'b0, 1'b1);
      if (c == 6) stop = 1'b1;
      step();
      clear_inputs();
    end

    // Start and stop together in IDLE keep the FSM idle.
    start = 1'b1;
    stop  = 1'b1;
    step();
    clear_inputs();
    expect_out("startstop", 1, 1'b0, 1'b0, 1'b0, 1'b1);

    // Burst of 3 at P=2.
    set_cfg(2, 1'b0, 3);
    start = 1'b1;
    step();
    clear_inputs();
    for (int c = 1; c <= 10; c++) begin
`ifdef EN_PULSE_GEN_BURST_EN
      expect_out("burst", c, (c <= 6) && (c % 2 == 0), (c <= 7), (c == 7), (c >= 8));
`else
      expect_out("burst", c, (c % 2 == 0), 1'b1, 1'b0, 1'b0);
`endif
      if (c == 10) stop = 1'b1;
      step();
      clear_inputs();
    end
    expect_out("burst", 11, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
